// File: rtl/eq_coeff_bank_ctrl_if.sv
// Equalizer read port, output-frame monitor and host staging bus for eq_coeff_bank_ctrl.
// Optional EQ_COEFF_READBACK_EN adds the shadow-bank readback signals.
interface eq_coeff_bank_ctrl_if #(
  parameter int unsigned NR_CHANNELS    = 3,
  parameter int unsigned NR_EQ_BANDS    = 8,
  parameter int unsigned EQ_COEFF_WIDTH = 32
);
  localparam int unsigned NR_EQ_COEFF = NR_CHANNELS * NR_EQ_BANDS * 5;
  localparam int unsigned ADDR_W      = $clog2(NR_EQ_COEFF);
  localparam int unsigned CH_W        = $clog2(NR_CHANNELS);

  logic [ADDR_W-1:0]         eq_coeff_addr;
  logic [EQ_COEFF_WIDTH-1:0] eq_coeff;
  logic [CH_W-1:0]           m_eq_ch;
  logic                      m_eq_dv;
  logic                      m_eq_dr;
  logic [ADDR_W-1:0]         cfg_addr;
  logic [EQ_COEFF_WIDTH-1:0] cfg_wdata;
  logic                      cfg_wr;
  logic                      cfg_commit;
  logic                      cfg_rdy;
  logic                      cfg_pending;
  logic                      cfg_done;
`ifdef EQ_COEFF_READBACK_EN
  logic                      cfg_rd;
  logic [EQ_COEFF_WIDTH-1:0] cfg_rdata;
  logic                      cfg_rdv;

  modport master (
    output eq_coeff_addr, m_eq_ch, m_eq_dv, m_eq_dr,
    output cfg_addr, cfg_wdata, cfg_wr, cfg_commit, cfg_rd,
    input  eq_coeff, cfg_rdy, cfg_pending, cfg_done, cfg_rdata, cfg_rdv
  );
  modport slave (
    input  eq_coeff_addr, m_eq_ch, m_eq_dv, m_eq_dr,
    input  cfg_addr, cfg_wdata, cfg_wr, cfg_commit, cfg_rd,
    output eq_coeff, cfg_rdy, cfg_pending, cfg_done, cfg_rdata, cfg_rdv
  );
`else
  modport master (
    output eq_coeff_addr, m_eq_ch, m_eq_dv, m_eq_dr,
    output cfg_addr, cfg_wdata, cfg_wr, cfg_commit,
    input  eq_coeff, cfg_rdy, cfg_pending, cfg_done
  );
  modport slave (
    input  eq_coeff_addr, m_eq_ch, m_eq_dv, m_eq_dr,
    input  cfg_addr, cfg_wdata, cfg_wr, cfg_commit,
    output eq_coeff, cfg_rdy, cfg_pending, cfg_done
  );
`endif
endinterface

// File: rtl/eq_coeff_bank_ctrl.sv
// Double-buffered biquad coefficient store: active bank feeds the equalizer, host stages into
// the shadow bank, swap happens on a frame boundary, then shadow is refreshed. Macro: EQ_COEFF_READBACK_EN.
module eq_coeff_bank_ctrl #(
  parameter int unsigned NR_CHANNELS    = 3,
  parameter int unsigned NR_EQ_BANDS    = 8,
  parameter int unsigned EQ_COEFF_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  eq_coeff_bank_ctrl_if.slave  bus
);
  localparam int unsigned NR_EQ_COEFF = NR_CHANNELS * NR_EQ_BANDS * 5;
  localparam int unsigned ADDR_W      = $clog2(NR_EQ_COEFF);
  localparam int unsigned CH_W        = $clog2(NR_CHANNELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NR_EQ_COEFF - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIM  = ADDR_W'(NR_EQ_COEFF);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NR_CHANNELS - 1);
  localparam logic [EQ_COEFF_WIDTH-1:0] UNITY = EQ_COEFF_WIDTH'(1) << (EQ_COEFF_WIDTH - 4);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_PENDING, ST_COPY} state_t;

  logic [EQ_COEFF_WIDTH-1:0] bank_q [2][NR_EQ_COEFF];

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         idx_q, idx_d;
  logic                      sel_q, sel_d;
  logic                      rdy_q, rdy_d;
  logic                      pending_q, pending_d;
  logic                      done_q, done_d;
  logic [EQ_COEFF_WIDTH-1:0] coeff_q, coeff_d;
`ifdef EQ_COEFF_READBACK_EN
  logic [EQ_COEFF_WIDTH-1:0] rdata_q, rdata_d;
  logic                      rdv_q, rdv_d;
`endif

  logic                      shadow_sel_c;
  logic                      frame_end_c;
  logic                      init_we_c;
  logic                      host_we_c;
  logic                      copy_we_c;
  logic [EQ_COEFF_WIDTH-1:0] unity_c;

  assign shadow_sel_c = ~sel_q;
  assign frame_end_c  = bus.m_eq_dv && bus.m_eq_dr && (bus.m_eq_ch == LAST_CH);
  assign unity_c      = ((idx_q % ADDR_W'(5)) == '0) ? UNITY : '0;

  // Sequencing: init sweep, host staging, frame-aligned swap, shadow refresh.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    init_we_c = 1'b0;
    host_we_c = 1'b0;
    copy_we_c = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we_c = 1'b1;
        idx_d     = idx_q + ADDR_W'(1);
        if (idx_q == LAST_ADDR) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        host_we_c = bus.cfg_wr && (bus.cfg_addr < ADDR_LIM);
        if (bus.cfg_commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_end_c) begin
          sel_d   = ~sel_q;
          idx_d   = '0;
          state_d = ST_COPY;
        end
      end
      ST_COPY: begin
        copy_we_c = 1'b1;
        idx_d     = idx_q + ADDR_W'(1);
        if (idx_q == LAST_ADDR) begin
          idx_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    rdy_d     = (state_d == ST_IDLE);
    pending_d = (state_d == ST_PENDING) || (state_d == ST_COPY);
    coeff_d   = (bus.eq_coeff_addr < ADDR_LIM) ? bank_q[sel_q][bus.eq_coeff_addr] : '0;

`ifdef EQ_COEFF_READBACK_EN
    // Read happens before any same-cycle host write lands, so it returns the old word.
    rdv_d   = bus.cfg_rd && (state_q == ST_IDLE);
    rdata_d = rdata_q;
    if (rdv_d) rdata_d = (bus.cfg_addr < ADDR_LIM) ? bank_q[shadow_sel_c][bus.cfg_addr] : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      sel_q     <= 1'b0;
      rdy_q     <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      coeff_q   <= '0;
`ifdef EQ_COEFF_READBACK_EN
      rdata_q   <= '0;
      rdv_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      rdy_q     <= rdy_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      coeff_q   <= coeff_d;
`ifdef EQ_COEFF_READBACK_EN
      rdata_q   <= rdata_d;
      rdv_q     <= rdv_d;
`endif
    end
  end

  // Bank storage; contents are rebuilt by the init sweep, so no reset.
  always_ff @(posedge clk) begin
    if (init_we_c) begin
      bank_q[0][idx_q] <= unity_c;
      bank_q[1][idx_q] <= unity_c;
    end
    if (host_we_c) bank_q[shadow_sel_c][bus.cfg_addr] <= bus.cfg_wdata;
    if (copy_we_c) bank_q[shadow_sel_c][idx_q] <= bank_q[sel_q][idx_q];
  end

  assign bus.eq_coeff    = coeff_q;
  assign bus.cfg_rdy     = rdy_q;
  assign bus.cfg_pending = pending_q;
  assign bus.cfg_done    = done_q;
`ifdef EQ_COEFF_READBACK_EN
  assign bus.cfg_rdata   = rdata_q;
  assign bus.cfg_rdv     = rdv_q;
`endif

endmodule

// File: tb/tb_eq_coeff_bank_ctrl.sv
// Self-checking bench for eq_coeff_bank_ctrl: directed and random stimulus against an
// array-based model of the active/shadow banks and the commit/swap/copy rules.
module tb_eq_coeff_bank_ctrl;
  localparam int unsigned NCH = 3;
  localparam int unsigned NB  = 8;
  localparam int unsigned W   = 32;
  localparam int unsigned N   = NCH * NB * 5;
  localparam int unsigned AW  = $clog2(N);
  localparam int unsigned CW  = $clog2(NCH);
  localparam logic [W-1:0] ONE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eq_coeff_bank_ctrl_if #(.NR_CHANNELS(NCH), .NR_EQ_BANDS(NB), .EQ_COEFF_WIDTH(W)) bus ();

  eq_coeff_bank_ctrl #(.NR_CHANNELS(NCH), .NR_EQ_BANDS(NB), .EQ_COEFF_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  string       phase    = "start";

  // Model: bank contents and where the host/swap protocol stands.
  logic [W-1:0] act  [N];
  logic [W-1:0] shad [N];
  int           init_left = 0;
  int           copy_left = 0;
  bit           pend      = 1'b0;

  logic [W-1:0] exp_coeff = '0;
  bit           coeff_known = 1'b0;
  bit           exp_rdy, exp_pend, exp_done;
  logic [W-1:0] exp_rdata = '0;
  bit           exp_rdv   = 1'b0;

  int unsigned  fixed_addr [5] = '{0, 5, 115, 1, 120};

  function automatic logic [W-1:0] unity(int a);
    return (a % 5 == 0) ? ONE : '0;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, expv);
    end
  endtask

  // Advance the model by the edge that is about to sample the current inputs.
  task automatic step();
    int  ea, ca;
    bit  fe;
    ea = int'(bus.eq_coeff_addr);
    ca = int'(bus.cfg_addr);
    fe = bus.m_eq_dv && bus.m_eq_dr && (int'(bus.m_eq_ch) == NCH - 1);
    exp_done = 1'b0;
    if (rst) begin
      init_left   = N;
      copy_left   = 0;
      pend        = 1'b0;
      exp_coeff   = '0;
      coeff_known = 1'b1;
      exp_rdata   = '0;
      exp_rdv     = 1'b0;
      for (int i = 0; i < N; i++) begin
        act[i]  = unity(i);
        shad[i] = unity(i);
      end
    end else begin
      coeff_known = (init_left == 0);
      exp_coeff   = (ea < N) ? act[ea] : '0;
      exp_rdv     = 1'b0;
      if (init_left > 0) begin
        init_left--;
      end else if (copy_left > 0) begin
        copy_left--;
        if (copy_left == 0) exp_done = 1'b1;
      end else if (pend) begin
        if (fe) begin
          act       = shad;
          pend      = 1'b0;
          copy_left = N;
        end
      end else begin
`ifdef EQ_COEFF_READBACK_EN
        if (bus.cfg_rd) begin
          exp_rdv   = 1'b1;
          exp_rdata = (ca < N) ? shad[ca] : '0;
        end
`endif
        if (bus.cfg_wr && ca < N) shad[ca] = bus.cfg_wdata;
        if (bus.cfg_commit) pend = 1'b1;
      end
    end
    exp_rdy  = !rst && init_left == 0 && !pend && copy_left == 0;
    exp_pend = !rst && (pend || copy_left > 0);
  endtask

  task automatic cycle();
    step();
    @(posedge clk);
    #1;
    if (coeff_known) check("eq_coeff", bus.eq_coeff, exp_coeff);
    check("cfg_rdy", W'(bus.cfg_rdy), W'(exp_rdy));
    check("cfg_pending", W'(bus.cfg_pending), W'(exp_pend));
    check("cfg_done", W'(bus.cfg_done), W'(exp_done));
`ifdef EQ_COEFF_READBACK_EN
    check("cfg_rdv", W'(bus.cfg_rdv), W'(exp_rdv));
    check("cfg_rdata", bus.cfg_rdata, exp_rdata);
`endif
  endtask

  task automatic quiet();
    bus.cfg_wr     = 1'b0;
    bus.cfg_commit = 1'b0;
    bus.m_eq_dv    = 1'b0;
    bus.m_eq_dr    = 1'b0;
    bus.m_eq_ch    = '0;
`ifdef EQ_COEFF_READBACK_EN
    bus.cfg_rd     = 1'b0;
`endif
  endtask

  task automatic frame_beat(input int ch, input bit dv, input bit dr);
    bus.m_eq_ch = CW'(ch);
    bus.m_eq_dv = dv;
    bus.m_eq_dr = dr;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    quiet();
    frame_beat(NCH - 1, 1'b1, 1'b1);
    while ((pend || copy_left > 0 || init_left > 0) && guard < 500) begin
      cycle();
      guard++;
    end
    quiet();
    check("drain_timeout", W'(guard >= 500), '0);
  endtask

  initial begin
    bus.eq_coeff_addr = '0;
    bus.cfg_addr      = '0;
    bus.cfg_wdata     = '0;
    quiet();

    phase = "reset";
    rst = 1'b1;
    repeat (3) cycle();

    phase = "init";
    rst = 1'b0;
    repeat (N) cycle();

    phase = "unity_reads";
    foreach (fixed_addr[i]) begin
      bus.eq_coeff_addr = AW'(fixed_addr[i]);
      cycle();
    end
    repeat (16) begin
      bus.eq_coeff_addr = AW'($urandom_range(0, 2**AW - 1));
      cycle();
    end

    phase = "stage_no_commit";
    for (int i = 0; i < 12; i++) begin
      bus.eq_coeff_addr = '0;
      frame_beat(i % NCH, 1'b1, 1'b1);
      bus.cfg_addr  = AW'($urandom_range(1, 2**AW - 1));
      bus.cfg_wdata = $urandom;
      bus.cfg_wr    = 1'b1;
      cycle();
    end
    bus.cfg_addr  = '0;
    bus.cfg_wdata = 32'h1800_0000;
    cycle();
    bus.cfg_wr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      frame_beat(i % NCH, 1'b1, 1'b1);
      cycle();
    end

    phase = "commit_same_fe";
    frame_beat(NCH - 1, 1'b1, 1'b1);
    bus.cfg_commit = 1'b1;
    cycle();
    bus.cfg_commit = 1'b0;

    phase = "ignored_fe";
    frame_beat(NCH - 1, 1'b1, 1'b0);
    cycle();
    frame_beat(NCH - 2, 1'b1, 1'b1);
    cycle();
    frame_beat(NCH - 1, 1'b0, 1'b1);
    bus.cfg_addr   = AW'(3);
    bus.cfg_wdata  = 32'hDEAD_BEEF;
    bus.cfg_wr     = 1'b1;
    bus.cfg_commit = 1'b1;
    cycle();
    bus.cfg_wr     = 1'b0;
    bus.cfg_commit = 1'b0;

    phase = "swap";
    frame_beat(NCH - 1, 1'b1, 1'b1);
    cycle();
    quiet();
    cycle();

    phase = "copy";
    repeat (N + 4) begin
      bus.eq_coeff_addr = AW'($urandom_range(0, 2**AW - 1));
      cycle();
    end

`ifdef EQ_COEFF_READBACK_EN
    phase = "readback";
    bus.cfg_rd   = 1'b1;
    bus.cfg_addr = AW'(3);
    cycle();
    bus.cfg_addr = '0;
    cycle();
    bus.cfg_addr = AW'(125);
    cycle();
    repeat (6) begin
      bus.cfg_addr = AW'($urandom_range(0, N - 1));
      cycle();
    end
    bus.cfg_addr  = AW'($urandom_range(1, N - 1));
    bus.cfg_wdata = $urandom;
    bus.cfg_wr    = 1'b1;
    cycle();
    bus.cfg_wr = 1'b0;
    cycle();
    quiet();
    cycle();
`endif

    phase = "random";
    repeat (600) begin
      bus.eq_coeff_addr = AW'($urandom_range(0, 2**AW - 1));
      bus.m_eq_ch       = CW'($urandom_range(0, 2**CW - 1));
      bus.m_eq_dv       = 1'($urandom_range(0, 1));
      bus.m_eq_dr       = 1'($urandom_range(0, 1));
      bus.cfg_addr      = AW'($urandom_range(0, 2**AW - 1));
      bus.cfg_wdata     = $urandom;
      bus.cfg_wr        = ($urandom_range(0, 2) == 0);
      bus.cfg_commit    = ($urandom_range(0, 15) == 0);
`ifdef EQ_COEFF_READBACK_EN
      bus.cfg_rd        = ($urandom_range(0, 3) == 0);
`endif
      cycle();
    end

    phase = "drain";
    drain();

    phase = "rst_mid_copy";
    bus.cfg_addr   = '0;
    bus.cfg_wdata  = 32'h2400_0000;
    bus.cfg_wr     = 1'b1;
    bus.cfg_commit = 1'b1;
    cycle();
    quiet();
    frame_beat(NCH - 1, 1'b1, 1'b1);
    cycle();
    quiet();
    repeat (50) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (N + 10) cycle();

    phase = "a0_after_reinit";
    for (int a = 0; a < N; a += 5) begin
      bus.eq_coeff_addr = AW'(a);
      cycle();
      if (a > 0) check("a0_word", bus.eq_coeff, ONE);
    end
    bus.eq_coeff_addr = '0;
    cycle();
    check("a0_last", bus.eq_coeff, ONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
